buzzer_sequencer: RTL and testbench

- Avalon-MM slave that sequences the balance-car buzzer: tone generation, on/off beep cadence and repeat count.
- Shares the single buzzer between two requesters: software (HPS/Nios register writes) and a hardware alarm line (tilt/low-battery fault), with the alarm taking priority.
- Drives the buzzer pin directly.

---
 rtl/buzzer_sequencer.sv | 218 +++++++++++++++++++++
 tb/tb_buzzer_sequencer.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/buzzer_sequencer.sv
// Avalon-MM buzzer sequencer: tone, on/off cadence and repeat count, shared between software and a hardware alarm.
// Define BUZZER_SEQ_ALARM_EN to enable alarm_req arbitration and the alarm source; otherwise alarm_req is ignored.
module buzzer_sequencer #(
    parameter int DIV_W    = 20,
    parameter int TIME_W   = 16,
    parameter int TICK_DIV = 50000,
    parameter int ALM_HALF = 12500,
    parameter int ALM_ON   = 100,
    parameter int ALM_OFF  = 100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    input  logic        alarm_req,
    output logic        buzzer_out,
    output logic        busy,
    output logic        irq
);

`ifdef BUZZER_SEQ_ALARM_EN
    localparam bit ALM_EN = 1'b1;
`else
    localparam bit ALM_EN = 1'b0;
`endif

    localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);

    localparam logic [1:0] SRC_NONE = 2'b00;
    localparam logic [1:0] SRC_SW   = 2'b01;
    localparam logic [1:0] SRC_ALM  = 2'b10;

    typedef enum logic [1:0] {S_IDLE, S_ON, S_OFF} state_t;

    state_t              r_state, w_next;
    logic                r_irq_en, r_done, r_busy, r_buzz;
    logic [1:0]          r_src;
    logic [DIV_W-1:0]    r_half, r_sh_half, r_tone;
    logic [TIME_W-1:0]   r_on, r_off, r_sh_on, r_sh_off, r_ph;
    logic [7:0]          r_rep, r_rem;
    logic [PRE_W-1:0]    r_pre;

    logic                w_wr, w_start, w_stop, w_alm;
    logic                w_load_sw, w_load_alm, w_enter_on, w_enter_off, w_go_idle;
    logic                w_set_done, w_on_end, w_phase_end;
    logic [TIME_W-1:0]   w_on_n, w_cur_n;
    logic                w_unused_ok;

    assign w_wr        = chipselect & ~write_n;
    assign w_start     = w_wr && (address == 3'd0) && writedata[0];
    assign w_stop      = w_wr && (address == 3'd0) && writedata[1];
    assign w_alm       = ALM_EN & alarm_req;
    assign w_unused_ok = ^writedata;

    // ON_T=0 behaves as one tick; OFF_T=0 never reaches the OFF state
    assign w_on_n      = (r_sh_on == '0) ? TIME_W'(1) : r_sh_on;
    assign w_cur_n     = (r_state == S_ON) ? w_on_n : r_sh_off;
    assign w_phase_end = (r_pre == PRE_MAX) && (r_ph == w_cur_n - TIME_W'(1));

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        w_load_sw   = 1'b0;
        w_load_alm  = 1'b0;
        w_enter_on  = 1'b0;
        w_enter_off = 1'b0;
        w_go_idle   = 1'b0;
        w_set_done  = 1'b0;
        w_on_end    = 1'b0;
        if (w_alm && (r_state == S_IDLE || r_src == SRC_SW)) begin
            w_next     = S_ON;
            w_load_alm = 1'b1;
            w_enter_on = 1'b1;
        end else if (r_state != S_IDLE && r_src == SRC_ALM && !w_alm) begin
            w_next    = S_IDLE;
            w_go_idle = 1'b1;
        end else if (w_stop && r_state != S_IDLE && r_src == SRC_SW) begin
            w_next    = S_IDLE;
            w_go_idle = 1'b1;
        end else if (w_start && !w_stop && (r_state == S_IDLE || r_src == SRC_SW)) begin
            w_next     = S_ON;
            w_load_sw  = 1'b1;
            w_enter_on = 1'b1;
        end else begin
            case (r_state)
                S_ON: if (w_phase_end) begin
                    w_on_end = 1'b1;
                    if (r_src == SRC_SW && r_rem == 8'd1) begin
                        w_next     = S_IDLE;
                        w_go_idle  = 1'b1;
                        w_set_done = 1'b1;
                    end else if (r_sh_off == '0) begin
                        w_enter_on = 1'b1;
                    end else begin
                        w_next      = S_OFF;
                        w_enter_off = 1'b1;
                    end
                end
                S_OFF: if (w_phase_end) begin
                    w_next     = S_ON;
                    w_enter_on = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_irq_en  <= 1'b0;
            r_done    <= 1'b0;
            r_busy    <= 1'b0;
            r_buzz    <= 1'b0;
            r_src     <= SRC_NONE;
            r_half    <= '0;
            r_on      <= '0;
            r_off     <= '0;
            r_rep     <= '0;
            r_sh_half <= '0;
            r_sh_on   <= '0;
            r_sh_off  <= '0;
            r_rem     <= '0;
            r_tone    <= '0;
            r_ph      <= '0;
            r_pre     <= '0;
        end else begin
            if (w_wr) begin
                case (address)
                    3'd0: r_irq_en <= writedata[2];
                    3'd2: r_half   <= writedata[DIV_W-1:0];
                    3'd3: r_on     <= writedata[TIME_W-1:0];
                    3'd4: r_off    <= writedata[TIME_W-1:0];
                    3'd5: r_rep    <= writedata[7:0];
                    default: ;
                endcase
            end

            if (w_set_done)
                r_done <= 1'b1;
            else if (w_wr && address == 3'd1 && writedata[1])
                r_done <= 1'b0;

            r_busy <= (w_next != S_IDLE);

            if (w_load_sw) begin
                r_sh_half <= r_half;
                r_sh_on   <= r_on;
                r_sh_off  <= r_off;
                r_rem     <= r_rep;
                r_src     <= SRC_SW;
            end else if (w_load_alm) begin
                r_sh_half <= DIV_W'(ALM_HALF);
                r_sh_on   <= TIME_W'(ALM_ON);
                r_sh_off  <= TIME_W'(ALM_OFF);
                r_rem     <= '0;
                r_src     <= SRC_ALM;
            end else if (w_go_idle) begin
                r_src <= SRC_NONE;
            end else if (w_on_end && r_rem != '0) begin
                r_rem <= r_rem - 8'd1;
            end

            // phase entry restarts tone, prescaler and tick counters
            if (w_enter_on) begin
                r_buzz <= 1'b1;
                r_tone <= '0;
                r_pre  <= '0;
                r_ph   <= '0;
            end else if (w_enter_off || w_go_idle) begin
                r_buzz <= 1'b0;
                r_tone <= '0;
                r_pre  <= '0;
                r_ph   <= '0;
            end else if (r_state != S_IDLE) begin
                if (r_pre == PRE_MAX) begin
                    r_pre <= '0;
                    r_ph  <= r_ph + TIME_W'(1);
                end else begin
                    r_pre <= r_pre + PRE_W'(1);
                end
                if (r_state == S_ON && r_sh_half != '0) begin
                    if (r_tone == r_sh_half - DIV_W'(1)) begin
                        r_tone <= '0;
                        r_buzz <= ~r_buzz;
                    end else begin
                        r_tone <= r_tone + DIV_W'(1);
                    end
                end
            end
        end
    end

    always_comb begin
        readdata = 32'd0;
        case (address)
            3'd0: readdata = {29'd0, r_irq_en, 2'b00};
            3'd1: readdata = {28'd0, r_src, r_done, r_busy};
            3'd2: readdata = 32'(r_half);
            3'd3: readdata = 32'(r_on);
            3'd4: readdata = 32'(r_off);
            3'd5: readdata = {24'd0, r_rep};
            default: readdata = 32'd0;
        endcase
    end

    assign buzzer_out = r_buzz;
    assign busy       = r_busy;
    assign irq        = r_done & r_irq_en;

endmodule

// File: tb/tb_buzzer_sequencer.sv
// Bench for buzzer_sequencer: a waveform model pushes expected buzzer_out/busy per cycle, compared as the DUT runs.
module tb_buzzer_sequencer;

    localparam int TD = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  address = '0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic        alarm_req = 1'b0;
    logic        buzzer_out, busy, irq;

    typedef struct packed {
        logic buz;
        logic bsy;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    buzzer_sequencer #(
        .DIV_W(20), .TIME_W(16), .TICK_DIV(TD),
        .ALM_HALF(4), .ALM_ON(2), .ALM_OFF(1)
    ) dut (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata),
        .alarm_req(alarm_req), .buzzer_out(buzzer_out), .busy(busy), .irq(irq)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = a;
        writedata  = d;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
    endtask

    // Independent cadence model: ON phases sample (k/half) parity, OFF phases are low.
    task automatic push_run(input int half, input int on_t, input int off_t, input int rep, input int cap);
        int onl, offl, reps, n;
        onl  = ((on_t == 0) ? 1 : on_t) * TD;
        offl = off_t * TD;
        reps = 0;
        n    = 0;
        while (n < cap) begin
            for (int k = 0; k < onl && n < cap; k++) begin
                exp_q.push_back('{buz: (half == 0) ? 1'b1 : (((k / half) % 2) == 0), bsy: 1'b1});
                n++;
            end
            reps++;
            if (rep != 0 && reps == rep) begin
                exp_q.push_back('{buz: 1'b0, bsy: 1'b0});
                break;
            end
            for (int k = 0; k < offl && n < cap; k++) begin
                exp_q.push_back('{buz: 1'b0, bsy: 1'b1});
                n++;
            end
        end
    endtask

    task automatic check_stream(input string name, input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL %s: scoreboard empty at cycle %0d", name, i);
            end else begin
                e = exp_q.pop_front();
                if ({buzzer_out, busy} !== {e.buz, e.bsy}) begin
                    n_err++;
                    $display("FAIL %s cycle %0d: buzzer_out,busy=%b%b expected %b%b",
                             name, i, buzzer_out, busy, e.buz, e.bsy);
                end
            end
        end
    endtask

    task automatic test_reset;
        logic [31:0] v;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({buzzer_out, busy, irq} !== 3'b000) begin
            n_err++;
            $display("FAIL reset_outputs: got %b expected 000", {buzzer_out, busy, irq});
        end
        for (int a = 0; a < 8; a++) begin
            address = 3'(a);
            #1;
            v = readdata;
            n_cmp++;
            if (v !== 32'd0) begin
                n_err++;
                $display("FAIL reset_read addr %0d: got %h expected 0", a, v);
            end
        end
    endtask

    task automatic test_repeat;
        logic [31:0] exp_rd [6];
        wr(3'd2, 32'd3);
        wr(3'd3, 32'd2);
        wr(3'd4, 32'd1);
        wr(3'd5, 32'd2);
        wr(3'd0, 32'd4);
        exp_rd = '{32'd4, 32'd0, 32'd3, 32'd2, 32'd1, 32'd2};
        for (int a = 0; a < 6; a++) begin
            address = 3'(a);
            #1;
            n_cmp++;
            if (readdata !== exp_rd[a]) begin
                n_err++;
                $display("FAIL reg_readback addr %0d: got %h expected %h", a, readdata, exp_rd[a]);
            end
        end
        wr(3'd0, 32'd5);
        push_run(3, 2, 1, 2, 10000);
        check_stream("repeat2", exp_q.size());
        address = 3'd1;
        #1;
        n_cmp++;
        if (readdata !== 32'h2 || irq !== 1'b1) begin
            n_err++;
            $display("FAIL repeat_done: status=%h irq=%b expected 2 and 1", readdata, irq);
        end
        wr(3'd1, 32'd2);
        address = 3'd1;
        #1;
        n_cmp++;
        if (readdata !== 32'h0 || irq !== 1'b0) begin
            n_err++;
            $display("FAIL done_clear: status=%h irq=%b expected 0 and 0", readdata, irq);
        end
    endtask

    task automatic test_continuous_stop;
        wr(3'd2, 32'd0);
        wr(3'd3, 32'd1);
        wr(3'd4, 32'd1);
        wr(3'd5, 32'd0);
        wr(3'd0, 32'd1);
        push_run(0, 1, 1, 0, 45);
        check_stream("continuous", 45);
        wr(3'd0, 32'd2);
        exp_q.push_back('{buz: 1'b0, bsy: 1'b0});
        check_stream("stop", 1);
        address = 3'd1;
        #1;
        n_cmp++;
        if (readdata !== 32'h0) begin
            n_err++;
            $display("FAIL stop_no_done: status=%h expected 0", readdata);
        end
    endtask

    task automatic test_alarm;
`ifdef BUZZER_SEQ_ALARM_EN
        wr(3'd2, 32'd3);
        wr(3'd3, 32'd2);
        wr(3'd4, 32'd1);
        wr(3'd5, 32'd0);
        wr(3'd0, 32'd1);
        push_run(3, 2, 1, 0, 7);
        check_stream("sw_before_alarm", 7);
        alarm_req = 1'b1;
        push_run(4, 2, 1, 0, 35);
        check_stream("alarm_first", 1);
        address = 3'd1;
        #1;
        n_cmp++;
        if (readdata !== 32'h9) begin
            n_err++;
            $display("FAIL alarm_source: status=%h expected 9", readdata);
        end
        check_stream("alarm", 34);
        alarm_req = 1'b0;
        exp_q.push_back('{buz: 1'b0, bsy: 1'b0});
        check_stream("alarm_release", 1);
        address = 3'd1;
        #1;
        n_cmp++;
        if (readdata !== 32'h0) begin
            n_err++;
            $display("FAIL alarm_no_done: status=%h expected 0", readdata);
        end
`else
        wr(3'd2, 32'd0);
        wr(3'd3, 32'd1);
        wr(3'd4, 32'd1);
        wr(3'd5, 32'd1);
        alarm_req = 1'b1;
        exp_q.push_back('{buz: 1'b0, bsy: 1'b0});
        exp_q.push_back('{buz: 1'b0, bsy: 1'b0});
        check_stream("alarm_ignored_idle", 2);
        wr(3'd0, 32'd1);
        push_run(0, 1, 1, 1, 10000);
        check_stream("alarm_ignored_run", exp_q.size());
        alarm_req = 1'b0;
        wr(3'd1, 32'd2);
`endif
    endtask

    task automatic test_start_stop_same;
        wr(3'd0, 32'd3);
        repeat (3) exp_q.push_back('{buz: 1'b0, bsy: 1'b0});
        check_stream("start_stop_same", 3);
    endtask

    task automatic test_back_to_back;
        wr(3'd2, 32'd2);
        wr(3'd3, 32'd1);
        wr(3'd4, 32'd0);
        wr(3'd5, 32'd3);
        wr(3'd0, 32'd1);
        push_run(2, 1, 0, 3, 10000);
        check_stream("no_off_gap", exp_q.size());
        wr(3'd1, 32'd2);
    endtask

    task automatic test_rewrite_half;
        wr(3'd2, 32'd3);
        wr(3'd3, 32'd1);
        wr(3'd4, 32'd1);
        wr(3'd5, 32'd2);
        wr(3'd0, 32'd1);
        push_run(3, 1, 1, 2, 10000);
        check_stream("rewrite_pre", 5);
        wr(3'd2, 32'd1);
        check_stream("rewrite_post", exp_q.size());
        wr(3'd5, 32'd1);
        wr(3'd0, 32'd1);
        push_run(1, 1, 1, 1, 10000);
        check_stream("new_half", exp_q.size());
        wr(3'd1, 32'd2);
    endtask

    task automatic test_reset_mid_on;
        wr(3'd2, 32'd0);
        wr(3'd3, 32'd1);
        wr(3'd4, 32'd1);
        wr(3'd5, 32'd0);
        wr(3'd0, 32'd1);
        push_run(0, 1, 1, 0, 3);
        check_stream("pre_reset", 3);
        reset = 1'b1;
        exp_q.push_back('{buz: 1'b0, bsy: 1'b0});
        check_stream("reset_mid_on", 1);
        reset = 1'b0;
        address = 3'd3;
        #1;
        n_cmp++;
        if (readdata !== 32'd0) begin
            n_err++;
            $display("FAIL reset_clears_regs: ON_T=%h expected 0", readdata);
        end
    endtask

    initial begin
        test_reset();
        test_repeat();
        test_continuous_stop();
        test_alarm();
        test_start_stop_same();
        test_back_to_back();
        test_rewrite_half();
        test_reset_mid_on();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
